// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial arithmetic blocks.
//   state_e    : control FSM states (IDLE -> RUN -> DONE -> IDLE)
//   cnt_width  : width of a bit counter that can hold 0..w
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor built from gate primitives.
//   a, b  : minuend / subtrahend bits
//   bin   : borrow in
//   diff  : a ^ b ^ bin
//   bout  : (~a & b) | (~(a ^ b) & bin)
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  logic w_axb;
  logic w_na;
  logic w_nxb;
  logic w_t1;
  logic w_t2;

  xor g_x0 (w_axb, a, b);
  xor g_x1 (diff, w_axb, bin);
  not g_n0 (w_na, a);
  and g_a0 (w_t1, w_na, b);
  not g_n1 (w_nxb, w_axb);
  and g_a1 (w_t2, w_nxb, bin);
  or  g_o0 (bout, w_t1, w_t2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = a - b - bin (mod 2^WIDTH),
// one bit per clock, LSB first, through a single full-subtractor cell.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, bin           : minuend, subtrahend, borrow-in (sampled at handshake)
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   d                   : difference
//   bout                : final borrow (unsigned a < b + bin)
//   ovf                 : signed overflow, (a[MSB]!=b[MSB]) & (d[MSB]!=a[MSB])
//   zero                : d == 0
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [WIDTH-1:0] r_d;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_diff;
  logic             w_bout;
  logic [WIDTH-1:0] w_d_next;

  full_subtractor u_fs (
    .diff (w_diff),
    .bout (w_bout),
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br)
  );

  // Result fills from the MSB side so bit 0 lands at position 0 after WIDTH shifts.
  assign w_d_next = {w_diff, r_d[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_br        <= 1'b0;
      r_d         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_br       <= bin;
            r_cnt      <= '0;
            r_d        <= '0;
            r_bout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bout;
          r_d   <= w_d_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            // The last slice sees the operand MSBs, so overflow is taken here
            // rather than keeping separate copies of the latched sign bits.
            r_bout      <= w_bout;
            r_ovf       <= (r_a[0] ^ r_b[0]) & (w_diff ^ r_a[0]);
            r_zero      <= ~|w_d_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign d         = r_d;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases,
// backpressure, input isolation, mid-run reset and randomized operands
// compared against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;
  logic         zero;

  int n_checks;
  int n_errors;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction; ovf follows the documented sign-bit rule.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] md, output logic mbo, output logic movf,
                       output logic mz);
    int full;
    full = int'(ma) - int'(mb) - int'(mbin);
    md   = W'(full);
    mbo  = (full < 0);
    movf = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
    mz   = (md == '0);
  endtask

  // One full operation. noise scrambles inputs and in_valid after acceptance;
  // stall is the number of DONE cycles with out_ready held low.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       input bit noise, input int stall);
    logic [W-1:0] ed;
    logic         ebo;
    logic         eovf;
    logic         ez;
    int           cyc;
    model(oa, ob, obin, ed, ebo, eovf, ez);

    @(negedge clk);
    in_valid  = 1'b1;
    a         = oa;
    b         = ob;
    bin       = obin;
    out_ready = 1'($urandom_range(0, 1));
    check("in_ready_idle", in_ready, 1);
    check("out_valid_idle", out_valid, 0);
    @(posedge clk);

    cyc = 0;
    forever begin
      @(negedge clk);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid || cyc >= 30) break;
      if (in_ready !== 1'b0) check("in_ready_run", in_ready, 0);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      cyc++;
    end
    check("latency", cyc, W);
    check("out_valid", out_valid, 1);
    check("d", d, ed);
    check("bout", bout, ebo);
    check("ovf", ovf, eovf);
    check("zero", zero, ez);
    check("in_ready_done", in_ready, 0);

    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (noise) begin
        in_valid = 1'b1;
        a        = W'($urandom);
      end
      check("stall_valid", out_valid, 1);
      check("stall_d", d, ed);
      check("stall_flags", {bout, ovf, zero}, {ebo, eovf, ez});
    end

    // Result handshake; in_valid may be high here and must not be taken.
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("hs_valid_low", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_d", d, 0);
    check("rst_flags", {bout, ovf, zero}, 3'b000);
    rst_n = 1'b1;

    do_op(8'h05, 8'h03, 1'b0, 1'b0, 0);
    do_op(8'h03, 8'h05, 1'b0, 1'b0, 1);
    do_op(8'h80, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h00, 8'hFF, 1'b0, 1'b0, 2);
    do_op(8'h10, 8'h0F, 1'b1, 1'b0, 0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h80, 8'h00, 1'b1, 1'b0, 0);
    do_op(8'h7F, 8'hFF, 1'b0, 1'b1, 5);

    // Abort mid-run: reset lands while bit 4 is being processed.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h5A;
    b        = 8'h21;
    bin      = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_d", d, 0);
    check("abort_flags", {bout, ovf, zero}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_ready", in_ready, 1);
    do_op(8'hAA, 8'h55, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
